// File: rtl/matrix_job_seq.sv
// matrix_job_seq: expands one host multiply command into DIM x DIM engine dot-product jobs
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host_wr/rd/addr/wdata, host_ack/rdata   host register slave (ack one cycle after strobe)
//   calc_wr/addr/wdata, calc_ack             engine cfg master (held until ack, one write in flight)
//   calc_done                                 engine job-done pulse, honoured only while waiting
//   irq                                       one-cycle pulse on command completion or timeout abort
module matrix_job_seq #(
  parameter int DIM     = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_wr,
  input  logic        host_rd,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        calc_wr,
  output logic [7:0]  calc_addr,
  output logic [31:0] calc_wdata,
  input  logic        calc_ack,
  input  logic        calc_done,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, PROG, START, WAIT, NEXT} state_t;
  localparam logic [7:0]  LAST = 8'(DIM - 1);
  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);
  state_t      state_q;
  logic [63:0] a_q, b_q, c_q, aw_q, bw_q, cw_q;
  logic [7:0]  i_q, j_q;
  logic [2:0]  idx_q;
  logic [31:0] timer_q;
  logic        busy_q, done_q, errb_q, errt_q;
  logic        host_ack_q, calc_wr_q, irq_q;
  logic [31:0] host_rdata_q, calc_wdata_q, rdata_d, prog_data;
  logic [7:0]  calc_addr_q, prog_addr;
  logic [63:0] mat1, mat2, dst, sel;
  logic        start_req, rd_status;
  assign start_req = host_wr && host_addr == 8'h00 && host_wdata[0];
  assign rd_status = host_rd && host_addr == 8'h04;
  // Job addresses are full 64-bit sums so carries propagate into the high words.
  assign mat1 = aw_q + (64'(i_q) << 6);
  assign mat2 = bw_q + (64'(j_q) << 2);
  assign dst  = cw_q + ((64'(DIM) * 64'(i_q) + 64'(j_q)) << 3);
  // idx 0..5 walks mat1 lo/hi, mat2 lo/hi, dst lo/hi at engine 0x10..0x24.
  assign sel       = idx_q[2:1] == 2'd0 ? mat1 : idx_q[2:1] == 2'd1 ? mat2 : dst;
  assign prog_data = idx_q[0] ? sel[63:32] : sel[31:0];
  assign prog_addr = 8'h10 + {3'b0, idx_q, 2'b0};
  always_comb begin
    rdata_d = host_addr == 8'h04 ? {28'h0, errt_q, errb_q, done_q, busy_q}
            : host_addr == 8'h10 ? a_q[31:0]  : host_addr == 8'h14 ? a_q[63:32]
            : host_addr == 8'h18 ? b_q[31:0]  : host_addr == 8'h1C ? b_q[63:32]
            : host_addr == 8'h20 ? c_q[31:0]  : host_addr == 8'h24 ? c_q[63:32]
            : host_addr == 8'h28 ? {16'h0, i_q, j_q} : 32'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      aw_q         <= '0;
      bw_q         <= '0;
      cw_q         <= '0;
      i_q          <= '0;
      j_q          <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      errb_q       <= 1'b0;
      errt_q       <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      calc_wr_q    <= 1'b0;
      calc_addr_q  <= '0;
      calc_wdata_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      host_ack_q   <= host_wr | host_rd;
      host_rdata_q <= host_rd ? rdata_d : 32'h0;
      irq_q        <= 1'b0;
      // Read-to-clear happens first so a same-cycle status event still wins.
      if (rd_status) begin
        done_q <= 1'b0;
        errb_q <= 1'b0;
        errt_q <= 1'b0;
      end
      if (host_wr) begin
        case (host_addr)
          8'h10: a_q[31:0]  <= host_wdata;
          8'h14: a_q[63:32] <= host_wdata;
          8'h18: b_q[31:0]  <= host_wdata;
          8'h1C: b_q[63:32] <= host_wdata;
          8'h20: c_q[31:0]  <= host_wdata;
          8'h24: c_q[63:32] <= host_wdata;
          default: ;
        endcase
      end
      if (start_req && state_q != IDLE) errb_q <= 1'b1;
      case (state_q)
        IDLE: if (start_req) begin
          aw_q    <= a_q;
          bw_q    <= b_q;
          cw_q    <= c_q;
          i_q     <= '0;
          j_q     <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= PROG;
        end
        // Issue on an idle bus, retire on ack; the idle cycle after each ack separates writes.
        PROG: if (!calc_wr_q) begin
          calc_wr_q    <= 1'b1;
          calc_addr_q  <= prog_addr;
          calc_wdata_q <= prog_data;
        end else if (calc_ack) begin
          calc_wr_q <= 1'b0;
          idx_q     <= idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
          if (idx_q == 3'd5) state_q <= START;
        end
        START: if (!calc_wr_q) begin
          calc_wr_q    <= 1'b1;
          calc_addr_q  <= 8'h00;
          calc_wdata_q <= 32'h1;
        end else if (calc_ack) begin
          calc_wr_q <= 1'b0;
          timer_q   <= '0;
          state_q   <= WAIT;
        end
        WAIT: if (calc_done) state_q <= NEXT;
        else if (timer_q == TLIM) begin
          errt_q  <= 1'b1;
          busy_q  <= 1'b0;
          irq_q   <= 1'b1;
          state_q <= IDLE;
        end else timer_q <= timer_q + 32'd1;
        NEXT: if (j_q < LAST) begin
          j_q     <= j_q + 8'd1;
          state_q <= PROG;
        end else if (i_q < LAST) begin
          j_q     <= '0;
          i_q     <= i_q + 8'd1;
          state_q <= PROG;
        end else begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          irq_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign calc_wr    = calc_wr_q;
  assign calc_addr  = calc_addr_q;
  assign calc_wdata = calc_wdata_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_matrix_job_seq.sv
// tb_matrix_job_seq: scoreboard bench for matrix_job_seq with an ack/done engine model
module tb_matrix_job_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        host_wr = 1'b0, host_rd = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack, calc_wr, irq;
  logic [31:0] host_rdata, calc_wdata;
  logic [7:0]  calc_addr;
  logic        calc_ack = 1'b0, calc_done = 1'b0;
  logic        done_en = 1'b1;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, irq_cnt = 0, irq_cyc = 0, t_ack = 0;
  logic [39:0] cq[$];
  logic [40:0] hq[$];

  matrix_job_seq #(.DIM(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .calc_wr(calc_wr), .calc_addr(calc_addr), .calc_wdata(calc_wdata),
    .calc_ack(calc_ack), .calc_done(calc_done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine model: ack one cycle after calc_wr is seen, done 20 cycles after the start ack.
  initial begin
    int wcyc = 0, dcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        calc_ack = 1'b0;
        calc_done = 1'b0;
        wcyc = 0;
        dcnt = 0;
      end else begin
        calc_done = 1'b0;
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) calc_done = 1'b1;
        end
        if (calc_ack && calc_addr == 8'h00 && done_en) dcnt = 20;
        if (calc_wr && !calc_ack) wcyc++;
        else wcyc = 0;
        calc_ack = (wcyc == 2);
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents a write, an ack or an irq.
  initial begin
    logic [39:0] ce;
    logic [40:0] he;
    forever begin
      @(negedge clk);
      if (calc_wr && calc_ack) begin
        if (calc_addr == 8'h00) t_ack = cyc + 1;
        if (cq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL calc_write: unexpected addr %0h data %0h, none required", calc_addr, calc_wdata);
        end else begin
          ce = cq.pop_front();
          check("calc_write", {24'h0, calc_addr, calc_wdata}, {24'h0, ce});
        end
      end
      if (host_ack) begin
        if (hq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL host_ack: unexpected ack, none required");
        end else begin
          he = hq.pop_front();
          if (he[40]) check($sformatf("host_read_%02h", he[39:32]), {32'h0, host_rdata}, {32'h0, he[31:0]});
        end
      end
      if (irq) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    hq.push_back({1'b0, a, 32'h0});
    host_wr = 1'b1;
    host_addr = a;
    host_wdata = d;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    hq.push_back({1'b1, a, exp});
    host_rd = 1'b1;
    host_addr = a;
    @(negedge clk);
    host_rd = 1'b0;
  endtask

  task automatic set_bases(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    host_write(8'h10, a[31:0]);
    host_write(8'h14, a[63:32]);
    host_write(8'h18, b[31:0]);
    host_write(8'h1C, b[63:32]);
    host_write(8'h20, c[31:0]);
    host_write(8'h24, c[63:32]);
  endtask

  task automatic push_lit(input logic [31:0] m1, input logic [31:0] m1h, input logic [31:0] m2,
                          input logic [31:0] m2h, input logic [31:0] d, input logic [31:0] dh);
    cq.push_back({8'h10, m1});
    cq.push_back({8'h14, m1h});
    cq.push_back({8'h18, m2});
    cq.push_back({8'h1C, m2h});
    cq.push_back({8'h20, d});
    cq.push_back({8'h24, dh});
    cq.push_back({8'h00, 32'h1});
  endtask

  task automatic push_job(input int i, input int j);
    logic [63:0] m1, m2, d;
    m1 = 64'h1000 + 64'(64 * i);
    m2 = 64'h2000 + 64'(4 * j);
    d  = 64'h3000 + 64'(8 * (16 * i + j));
    push_lit(m1[31:0], m1[63:32], m2[31:0], m2[63:32], d[31:0], d[63:32]);
  endtask

  task automatic wait_irq(input int target, input int budget);
    for (int k = 0; k < budget && irq_cnt < target; k++) @(negedge clk);
    check("irq_wait", 64'(irq_cnt >= target), 64'h1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_calc_wr", 64'(calc_wr), 64'h0);
    check("rst_host_ack", 64'(host_ack), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_outs", {calc_addr, calc_wdata, host_rdata}, 64'h0);
    rst_n = 1'b1;
    host_read(8'h04, 32'h0);
    host_read(8'h28, 32'h0);
    host_read(8'h30, 32'h0);

    // Full command with a busy restart attempt and a base write during the run.
    set_bases(64'h1000, 64'h2000, 64'h3000);
    host_read(8'h18, 32'h2000);
    push_lit(32'h1000, 0, 32'h2000, 0, 32'h3000, 0);
    push_lit(32'h1000, 0, 32'h2004, 0, 32'h3008, 0);
    for (int k = 2; k < 255; k++) push_job(k / 16, k % 16);
    push_lit(32'h13C0, 0, 32'h203C, 0, 32'h37F8, 0);
    host_write(8'h00, 32'h1);
    repeat (100) @(negedge clk);
    host_write(8'h00, 32'h1);
    host_read(8'h04, 32'h5);
    host_read(8'h04, 32'h1);
    host_write(8'h10, 32'hDEAD_0000);
    wait_irq(1, 20000);
    repeat (10) @(negedge clk);
    check("irq_count_done", 64'(irq_cnt), 64'd1);
    check("calc_queue_done", 64'(cq.size()), 64'd0);
    host_read(8'h04, 32'h2);
    host_read(8'h04, 32'h0);
    host_read(8'h28, 32'h0F0F);
    host_read(8'h10, 32'hDEAD_0000);

    // Carry into the dst high word, then reset while job (0,2) is programming.
    set_bases(64'h0, 64'h0, 64'hFFFF_FFF8);
    push_lit(0, 0, 0, 0, 32'hFFFF_FFF8, 0);
    push_lit(0, 0, 32'h4, 0, 32'h0, 32'h1);
    host_write(8'h00, 32'h1);
    for (int k = 0; k < 500 && cq.size() != 0; k++) @(negedge clk);
    check("calc_queue_carry", 64'(cq.size()), 64'd0);
    for (int k = 0; k < 100 && !calc_wr; k++) @(negedge clk);
    check("calc_wr_before_reset", 64'(calc_wr), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_calc_wr", 64'(calc_wr), 64'h0);
    check("midreset_host_ack", 64'(host_ack), 64'h0);
    check("midreset_irq", 64'(irq), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    host_read(8'h04, 32'h0);
    host_read(8'h28, 32'h0);
    host_read(8'h20, 32'h0);
    repeat (30) @(negedge clk);
    check("calc_queue_after_reset", 64'(cq.size()), 64'd0);

    // Engine never finishes: timeout abort after TIMEOUT cycles.
    done_en = 1'b0;
    push_lit(0, 0, 0, 0, 0, 0);
    host_write(8'h00, 32'h1);
    wait_irq(2, 400);
    check("timeout_latency", 64'(irq_cyc - t_ack), 64'd64);
    host_read(8'h04, 32'h8);
    repeat (20) @(negedge clk);
    check("calc_queue_timeout", 64'(cq.size()), 64'd0);
    check("irq_count_timeout", 64'(irq_cnt), 64'd2);
    check("host_queue_end", 64'(hq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_job_seq.md
Name: matrix_job_seq

Overview:
- Upstream command sequencer for the dot-product calc engine. Turns one host "multiply" command into DIM×DIM dot-product jobs, which together form a full C = A × B.
- For each job it programs the engine's mat1, mat2 and dst address registers over a cfg-style bus, issues start, and waits for the engine's done pulse.
- Sits between the host cfg bus (slave side) and the calc engine cfg port (master side).

Parameters:
- DIM, 16, matrix dimension; fixed by the engine's 16-element row.
- TIMEOUT, 4096, cycles allowed per job from start to done before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- host_wr  in  1  host register write strobe
- host_rd  in  1  host register read strobe
- host_addr  in  8  host register address
- host_wdata  in  32  host write data
- host_ack  out  1  host access acknowledge
- host_rdata  out  32  host read data
- calc_wr  out  1  write strobe to engine cfg port
- calc_addr  out  8  engine register address
- calc_wdata  out  32  engine write data
- calc_ack  in  1  engine cfg acknowledge
- calc_done  in  1  engine single-cycle job-done pulse
- irq  out  1  one-cycle pulse when a command completes or aborts

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; base registers, row/column counters, STATUS and TIMER cleared.
- Host registers:
  - 0x00 CTRL: write with bit0=1 starts a command. When busy the write is ignored and ERR_BUSY is set.
  - 0x04 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ERR_BUSY, bit3 ERR_TIMEOUT. A host read clears bits 1-3 after the data is returned.
  - 0x10/0x14 A base lo/hi; 0x18/0x1C B base lo/hi; 0x20/0x24 C base lo/hi. These are RW and are latched into working copies at command start.
  - 0x28 PROGRESS (RO): {16'h0, row[7:0], col[7:0]}.
  - Any other address: reads return 0, writes are ignored.
  - host_ack pulses high the cycle after any host_rd or host_wr; host_rdata is valid in that same cycle.
- Engine job addresses, 64-bit, for row i and column j:
  - mat1 = A + 64·i
  - mat2 = B + 4·j
  - dst = C + 8·(DIM·i + j)
  - Each address is computed with 64-bit wraparound.
- Engine cfg handshake:
  - Drive calc_wr=1 with calc_addr and calc_wdata, and hold them until calc_ack=1 is sampled.
  - Deassert calc_wr in the cycle after ack. At most one write is outstanding.
- FSM:
  - IDLE: on a CTRL start, latch the bases, set i=j=0, set BUSY, go to PROG.
  - PROG: six sequential writes to engine addresses 0x10, 0x14, 0x18, 0x1C, 0x20, 0x24, in that order; then go to START.
  - START: write engine 0x00, wdata=1. On ack, clear TIMER and go to WAIT.
  - WAIT: on calc_done=1 go to NEXT. If TIMER reaches TIMEOUT-1 first, set ERR_TIMEOUT, clear BUSY, pulse irq, go to IDLE.
  - NEXT:
    - If j<DIM-1: increment j.
    - Else if i<DIM-1: j=0, increment i.
    - Otherwise (i=j=DIM-1): set DONE, clear BUSY, pulse irq, go to IDLE.
    - Go to PROG in the continuing cases; the transition takes 1 cycle.
- calc_done sampled outside WAIT is ignored.
- A host write to a base register while busy updates the register but not the working copy; the new value takes effect on the next command.
- A host start in the same cycle as completion (NEXT→IDLE) is ignored with ERR_BUSY set.
- Reset mid-command aborts immediately; no further calc_wr is issued.
- Minimum job latency, excluding engine time: 7 engine writes × (1 + ack latency + 1) cycles.

Test Plan:
- Program A=0x1000, B=0x2000, C=0x3000, write CTRL=1 with an engine model that acks after 1 cycle and pulses done 20 cycles after start.
  -> The first job writes 0x10=0x1000, 0x14=0, 0x18=0x2000, 0x1C=0, 0x20=0x3000, 0x24=0, then 0x00=1.
  -> The second job (j=1) writes 0x18=0x2004 and 0x20=0x3008.
- Same command, run to completion.
  -> 256 start writes; the last job has mat1=0x13C0, mat2=0x203C, dst=0x37F8; DONE=1; a single irq pulse; STATUS read returns 0x2, then 0x0.
- C base lo=0xFFFF_FFF8, hi=0: job (0,1) programs 0x20=0x0000_0000, 0x24=0x0000_0001 (carry into the high word).
- Write CTRL=1 again while BUSY.
  -> Ignored; STATUS=0x5; the ongoing sequence is unchanged.
- Engine never pulses done, TIMEOUT=64.
  -> 64 cycles after the start ack: ERR_TIMEOUT set, BUSY cleared, irq pulses, no further calc_wr.
- Assert rst_n=0 mid-PROG (calc_wr=1).
  -> calc_wr, host_ack and irq are 0 immediately; after release, STATUS=0 and PROGRESS=0.
